// File: rtl/ifetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues BRAM reads, and holds
// one returned instruction in a skid buffer so decode can stall without loss.
module ifetch_ctrl #(
   parameter int unsigned          PC_WIDTH    = 32,
   parameter int unsigned          IADDR_WIDTH = 10,
   parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   redirect_valid,
   input  logic [PC_WIDTH-1:0]    redirect_pc,
   output logic                   imem_en,
   output logic [IADDR_WIDTH-1:0] imem_addr,
   input  logic [31:0]            imem_rdata,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [PC_WIDTH-1:0]    out_pc,
   output logic [31:0]            out_instr
);

   localparam logic [PC_WIDTH-1:0] PcStep    = PC_WIDTH'(4);
   localparam logic [PC_WIDTH-1:0] ResetPcAl = {RESET_PC[PC_WIDTH-1:2], 2'b00};

   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic [PC_WIDTH-1:0] buf_pc_q, buf_pc_d;
   logic [31:0]         buf_instr_q, buf_instr_d;
   logic                inflight_valid_q, inflight_valid_d;
   logic                inflight_oor_q, inflight_oor_d;
   logic                buf_valid_q, buf_valid_d;

   logic [PC_WIDTH-1:0] issue_pc;
   logic [31:0]         data;
   logic                out_valid_int;
   logic                can_issue;
   logic                issue;

   always_comb begin
      issue_pc      = redirect_valid ? {redirect_pc[PC_WIDTH-1:2], 2'b00} : pc_q;
      out_valid_int = buf_valid_q | inflight_valid_q;
      can_issue     = out_ready | ~out_valid_int;
      issue         = redirect_valid | can_issue;
      // Fetches beyond the BRAM return a zero instruction instead of aliasing.
      data          = inflight_oor_q ? 32'h0 : imem_rdata;
   end

   // Reset gating keeps the BRAM idle while rst_n is held low.
   assign imem_en   = rst_n & issue;
   assign imem_addr = issue_pc[IADDR_WIDTH+1:2];
   assign out_valid = out_valid_int & ~redirect_valid;
   assign out_pc    = buf_valid_q ? buf_pc_q : inflight_pc_q;
   assign out_instr = buf_valid_q      ? buf_instr_q :
                      inflight_valid_q ? data        : 32'h0;

   always_comb begin
      pc_d             = pc_q;
      inflight_valid_d = inflight_valid_q;
      inflight_pc_d    = inflight_pc_q;
      inflight_oor_d   = inflight_oor_q;
      buf_valid_d      = buf_valid_q;
      buf_pc_d         = buf_pc_q;
      buf_instr_d      = buf_instr_q;

      if (issue) begin
         pc_d             = issue_pc + PcStep;
         inflight_valid_d = 1'b1;
         inflight_pc_d    = issue_pc;
         inflight_oor_d   = (issue_pc >> (IADDR_WIDTH + 2)) != '0;
      end else begin
         inflight_valid_d = 1'b0;
      end

      // Capture only happens when issue is blocked, so buf and inflight never overlap.
      if (redirect_valid || (buf_valid_q && out_ready)) begin
         buf_valid_d = 1'b0;
      end else if (inflight_valid_q && !out_ready) begin
         buf_valid_d = 1'b1;
         buf_pc_d    = inflight_pc_q;
         buf_instr_d = data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q             <= ResetPcAl;
         inflight_valid_q <= 1'b0;
         inflight_pc_q    <= '0;
         inflight_oor_q   <= 1'b0;
         buf_valid_q      <= 1'b0;
         buf_pc_q         <= '0;
         buf_instr_q      <= '0;
      end else begin
         pc_q             <= pc_d;
         inflight_valid_q <= inflight_valid_d;
         inflight_pc_q    <= inflight_pc_d;
         inflight_oor_q   <= inflight_oor_d;
         buf_valid_q      <= buf_valid_d;
         buf_pc_q         <= buf_pc_d;
         buf_instr_q      <= buf_instr_d;
      end
   end

endmodule
